// File: rtl/wb_stage_nw.sv
// N-lane writeback stage: registers retiring lanes toward the regfile and
// commit trace. The oldest redirecting lane wins and kills the younger lanes
// behind it. Wrong-path arrivals are squashed for SHADOW cycles after a
// redirect. Also handles stall/flush and keeps a wrapping retire counter.
//
// state  | meaning
// IDLE   | inputs accepted normally
// SQUASH | post-redirect shadow; every input lane is treated as invalid
module wb_stage_nw #(
    parameter int LANES  = 2,
    parameter int XLEN   = 64,
    parameter int RD_W   = 5,
    parameter int SHADOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall_i,
    input  logic                    flush_i,
    input  logic [LANES-1:0]        wb_valid_i,
    input  logic [LANES*RD_W-1:0]   wb_rd_i,
    input  logic [LANES*XLEN-1:0]   wb_value_i,
    input  logic [LANES*XLEN-1:0]   wb_pc_i,
    input  logic [LANES*32-1:0]     wb_inst_i,
    input  logic [LANES-1:0]        wb_redirect_i,
    input  logic [LANES*XLEN-1:0]   wb_redirect_pc_i,
    output logic [LANES-1:0]        wb_valid_o,
    output logic [LANES*RD_W-1:0]   wb_rd_o,
    output logic [LANES*XLEN-1:0]   wb_value_o,
    output logic [LANES*XLEN-1:0]   wb_pc_o,
    output logic [LANES*32-1:0]     wb_inst_o,
    output logic                    wb_redirect_o,
    output logic [XLEN-1:0]         wb_redirect_pc_o,
    output logic [63:0]             retire_cnt_o
);

    typedef enum logic {IDLE, SQUASH} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    accept;
    logic [LANES-1:0]        ev;
    logic [LANES-1:0]        keep;
    logic                    win;
    logic [XLEN-1:0]         win_pc;
    logic [63:0]             ret_inc;

    logic [LANES-1:0]        valid_q, valid_d;
    logic                    redirect_q, redirect_d;
    logic [XLEN-1:0]         redirect_pc_q, redirect_pc_d;
    logic [63:0]             retire_q, retire_d;
    logic [LANES*RD_W-1:0]   rd_q;
    logic [LANES*XLEN-1:0]   value_q;
    logic [LANES*XLEN-1:0]   pc_q;
    logic [LANES*32-1:0]     inst_q;

    assign accept = !stall_i && !flush_i;

    // Oldest-lane redirect arbitration; lanes after the winner are killed.
    always_comb begin
        ev      = wb_valid_i & {LANES{state_q == IDLE}};
        win     = 1'b0;
        keep    = '0;
        win_pc  = '0;
        ret_inc = '0;
        for (int k = 0; k < LANES; k++) begin
            if (!win) keep[k] = ev[k];
            if (!win && ev[k] && wb_redirect_i[k]) begin
                win    = 1'b1;
                win_pc = wb_redirect_pc_i[k*XLEN +: XLEN];
            end
        end
        for (int k = 0; k < LANES; k++) begin
            ret_inc = ret_inc + 64'(keep[k]);
        end
    end

    // FSM state register and shadow counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: flush wins, stall freezes, shadow counts non-stalled cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!stall_i) begin
            case (state_q)
                IDLE: begin
                    if (win && (SHADOW > 0)) begin
                        state_d = SQUASH;
                        cnt_d   = 4'(SHADOW);
                    end
                end
                SQUASH: begin
                    if (cnt_q <= 4'd1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output next values: redirect pulses once, its target holds until the next.
    always_comb begin
        valid_d       = valid_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        retire_d      = retire_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (accept) begin
            valid_d  = keep;
            retire_d = retire_q + ret_inc;
            if (win) begin
                redirect_d    = 1'b1;
                redirect_pc_d = win_pc;
            end
        end
    end

    // Control-side output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            retire_q      <= '0;
        end else begin
            valid_q       <= valid_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            retire_q      <= retire_d;
        end
    end

    // Lane data registers capture on every accepted cycle, valid or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            value_q <= '0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else if (accept) begin
            rd_q    <= wb_rd_i;
            value_q <= wb_value_i;
            pc_q    <= wb_pc_i;
            inst_q  <= wb_inst_i;
        end
    end

    assign wb_valid_o       = valid_q;
    assign wb_rd_o          = rd_q;
    assign wb_value_o       = value_q;
    assign wb_pc_o          = pc_q;
    assign wb_inst_o        = inst_q;
    assign wb_redirect_o    = redirect_q;
    assign wb_redirect_pc_o = redirect_pc_q;
    assign retire_cnt_o     = retire_q;

endmodule
